// File: rtl/console_pkg.sv
// Shared definitions for the text console writer: geometry defaults,
// ASCII control codes and the writer FSM state encoding.
package console_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    CLEAR_LINE = 2'd2,
    CLEAR_ALL  = 2'd3
  } state_e;

  // Glyph-producing codepoints: 0x20-0x7E and the whole upper half.
  function automatic logic is_printable(input logic [7:0] c);
    return ((c >= 8'h20) && (c <= 8'h7E)) || (c >= 8'h80);
  endfunction

endpackage

// File: rtl/console_addr_gen.sv
// Maps (logical row, row offset, column) to a text RAM address.
// Shared by the display fetch path and the writer path.
module console_addr_gen
  import console_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic [4:0]  row,
  input  logic [4:0]  offset,
  input  logic [6:0]  col,
  output logic [11:0] addr
);

  logic [5:0] sum;
  logic [4:0] phys_row;

  // row + offset never exceeds 2*ROWS-2, so a single conditional subtract is a full modulo.
  always_comb begin
    sum = {1'b0, row} + {1'b0, offset};
    if (sum >= 6'(ROWS)) begin
      sum = sum - 6'(ROWS);
    end
    phys_row = sum[4:0];
    addr     = 12'(phys_row) * 12'(COLS) + 12'(col);
  end

endmodule

// File: rtl/console_writer.sv
// Character-stream text console writer sharing one text RAM port with the
// display fetch, which always has priority.
// Optional macro CONSOLE_WRITER_SCROLL_EN: a newline on the last row scrolls
// the screen; without it the cursor wraps to row 0 and scroll_row stays 0.
module console_writer
  import console_pkg::*;
#(
  parameter int         COLS       = DEF_COLS,
  parameter int         ROWS       = DEF_ROWS,
  parameter logic [7:0] ATTR_BLANK = 8'h0F
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_char,
  input  logic [7:0]  in_attr,
  input  logic        disp_req,
  input  logic [4:0]  disp_row,
  input  logic [6:0]  disp_col,
  output logic        disp_valid,
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic [4:0]  scroll_row,
  output logic        busy
);

`ifdef CONSOLE_WRITER_SCROLL_EN
  localparam bit SCROLL_EN = 1'b1;
`else
  localparam bit SCROLL_EN = 1'b0;
`endif

  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [15:0] BLANK    = {ATTR_BLANK, SPACE};

  state_e      state_q, state_d;
  logic [4:0]  cursor_row_q, cursor_row_d;
  logic [6:0]  cursor_col_q, cursor_col_d;
  logic [4:0]  scroll_row_q, scroll_row_d;
  logic [4:0]  clr_row_q, clr_row_d;
  logic [6:0]  clr_col_q, clr_col_d;
  logic [6:0]  wr_col_q, wr_col_d;
  logic        wr_bs_q, wr_bs_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        disp_valid_q;

  logic        grant;
  logic [4:0]  ag_row;
  logic [4:0]  ag_off;
  logic [6:0]  ag_col;
  logic [11:0] ag_addr;

  // Read data is consumed by the display side directly from the RAM.
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;

  console_addr_gen #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_addr_gen (
    .row    (ag_row),
    .offset (ag_off),
    .col    (ag_col),
    .addr   (ag_addr)
  );

  // RAM port mux: display fetch wins; clears address physical rows directly (offset 0).
  always_comb begin
    grant  = ~disp_req;
    ag_row = clr_row_q;
    ag_off = '0;
    ag_col = clr_col_q;
    if (disp_req) begin
      ag_row = disp_row;
      ag_off = scroll_row_q;
      ag_col = disp_col;
    end else if (state_q == WRITE) begin
      ag_row = cursor_row_q;
      ag_off = scroll_row_q;
      ag_col = wr_col_q;
    end
  end

  assign ram_addr = ag_addr;

  // Writer FSM: next state, cursor/scroll updates and RAM write strobes.
  always_comb begin
    state_d      = state_q;
    cursor_row_d = cursor_row_q;
    cursor_col_d = cursor_col_q;
    scroll_row_d = scroll_row_q;
    clr_row_d    = clr_row_q;
    clr_col_d    = clr_col_q;
    wr_col_d     = wr_col_q;
    wr_bs_d      = wr_bs_q;
    wr_data_d    = wr_data_q;
    ram_we       = 1'b0;
    ram_wdata    = BLANK;
    in_ready     = (state_q == IDLE);
    busy         = (state_q == CLEAR_LINE) || (state_q == CLEAR_ALL);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_printable(in_char)) begin
            wr_col_d  = cursor_col_q;
            wr_bs_d   = 1'b0;
            wr_data_d = {in_attr, in_char};
            state_d   = WRITE;
          end else if (in_char == CR) begin
            cursor_col_d = '0;
          end else if (in_char == LF) begin
            if (cursor_row_q != LAST_ROW) begin
              cursor_col_d = '0;
              cursor_row_d = cursor_row_q + 5'd1;
            end else begin
              clr_row_d = SCROLL_EN ? scroll_row_q : 5'd0;
              clr_col_d = '0;
              state_d   = CLEAR_LINE;
            end
          end else if (in_char == BS) begin
            if (cursor_col_q != 7'd0) begin
              wr_col_d  = cursor_col_q - 7'd1;
              wr_bs_d   = 1'b1;
              wr_data_d = BLANK;
              state_d   = WRITE;
            end
          end else if (in_char == FF) begin
            clr_row_d = '0;
            clr_col_d = '0;
            state_d   = CLEAR_ALL;
          end
        end
      end

      WRITE: begin
        ram_we    = grant;
        ram_wdata = wr_data_q;
        if (grant) begin
          state_d = IDLE;
          if (wr_bs_q) begin
            cursor_col_d = wr_col_q;
          end else if (wr_col_q != LAST_COL) begin
            cursor_col_d = wr_col_q + 7'd1;
          end else if (cursor_row_q != LAST_ROW) begin
            cursor_col_d = '0;
            cursor_row_d = cursor_row_q + 5'd1;
          end else begin
            clr_row_d = SCROLL_EN ? scroll_row_q : 5'd0;
            clr_col_d = '0;
            state_d   = CLEAR_LINE;
          end
        end
      end

      CLEAR_LINE: begin
        ram_we = grant;
        if (grant) begin
          if (clr_col_q == LAST_COL) begin
            state_d      = IDLE;
            cursor_col_d = '0;
            cursor_row_d = SCROLL_EN ? cursor_row_q : 5'd0;
            if (SCROLL_EN) begin
              scroll_row_d = (scroll_row_q == LAST_ROW) ? 5'd0 : scroll_row_q + 5'd1;
            end else begin
              scroll_row_d = '0;
            end
          end else begin
            clr_col_d = clr_col_q + 7'd1;
          end
        end
      end

      CLEAR_ALL: begin
        ram_we = grant;
        if (grant) begin
          if (clr_col_q == LAST_COL) begin
            clr_col_d = '0;
            if (clr_row_q == LAST_ROW) begin
              state_d      = IDLE;
              cursor_row_d = '0;
              cursor_col_d = '0;
              scroll_row_d = '0;
            end else begin
              clr_row_d = clr_row_q + 5'd1;
            end
          end else begin
            clr_col_d = clr_col_q + 7'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // No write may escape while reset holds the FSM in CLEAR_ALL.
    if (reset) begin
      ram_we = 1'b0;
    end
  end

  // Control state; reset restarts a full-screen clear from address 0.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q      <= CLEAR_ALL;
      cursor_row_q <= '0;
      cursor_col_q <= '0;
      scroll_row_q <= '0;
      clr_row_q    <= '0;
      clr_col_q    <= '0;
      wr_col_q     <= '0;
      wr_bs_q      <= 1'b0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cursor_row_q <= cursor_row_d;
      cursor_col_q <= cursor_col_d;
      scroll_row_q <= scroll_row_d;
      clr_row_q    <= clr_row_d;
      clr_col_q    <= clr_col_d;
      wr_col_q     <= wr_col_d;
      wr_bs_q      <= wr_bs_d;
      disp_valid_q <= disp_req;
    end
  end

  // Pending write data needs no reset; it is always loaded before use.
  always_ff @(posedge clk_pixel) begin
    wr_data_q <= wr_data_d;
  end

  assign disp_valid = disp_valid_q;
  assign cursor_row = cursor_row_q;
  assign cursor_col = cursor_col_q;
  assign scroll_row = scroll_row_q;

endmodule

// File: tb/tb_console_writer.sv
// Scoreboard bench for console_writer: expected RAM writes are queued as
// characters are driven and matched against every observed ram_we cycle.
module tb_console_writer;

  localparam int COLS = 80;
  localparam int ROWS = 30;
`ifdef CONSOLE_WRITER_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic        clk_pixel = 1'b0;
  logic        reset     = 1'b1;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char   = 8'h00;
  logic [7:0]  in_attr   = 8'h00;
  logic        disp_req  = 1'b0;
  logic [4:0]  disp_row  = 5'd0;
  logic [6:0]  disp_col  = 7'd0;
  logic        disp_valid;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = 16'h0000;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic [4:0]  scroll_row;
  logic        busy;

  int tests = 0;
  int fails = 0;
  logic [27:0] exp_q[$];
  int exp_row = 0, exp_col = 0, exp_scroll = 0;
  logic prev_req = 1'b0;
  logic [4:0] snap_row, snap_scroll;
  logic [6:0] snap_col;
  int last_wait;

  console_writer dut (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .in_attr    (in_attr),
    .disp_req   (disp_req),
    .disp_row   (disp_row),
    .disp_col   (disp_col),
    .disp_valid (disp_valid),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .scroll_row (scroll_row),
    .busy       (busy)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] addr_of(input int r, input int c);
    return 12'(((r + exp_scroll) % ROWS) * COLS + c);
  endfunction

  function automatic void push_row(input int pr);
    for (int c = 0; c < COLS; c++) exp_q.push_back({12'(pr * COLS + c), 16'h0F20});
  endfunction

  function automatic void newline(input bit push_en);
    if (exp_row < ROWS - 1) begin
      exp_row++;
    end else if (SCROLL) begin
      if (push_en) push_row(exp_scroll);
      exp_scroll = (exp_scroll + 1) % ROWS;
    end else begin
      if (push_en) push_row(0);
      exp_row = 0;
    end
  endfunction

  // Reference behaviour of one accepted codepoint.
  function automatic void model(input logic [7:0] c, input logic [7:0] a, input bit push_en);
    if ((c >= 8'h20 && c <= 8'h7E) || c >= 8'h80) begin
      if (push_en) exp_q.push_back({addr_of(exp_row, exp_col), a, c});
      exp_col++;
      if (exp_col == COLS) begin
        exp_col = 0;
        newline(push_en);
      end
    end else if (c == 8'h0D) begin
      exp_col = 0;
    end else if (c == 8'h0A) begin
      exp_col = 0;
      newline(push_en);
    end else if (c == 8'h08) begin
      if (exp_col > 0) begin
        exp_col--;
        if (push_en) exp_q.push_back({addr_of(exp_row, exp_col), 16'h0F20});
      end
    end else if (c == 8'h0C) begin
      if (push_en) for (int r = 0; r < ROWS; r++) push_row(r);
      exp_row = 0; exp_col = 0; exp_scroll = 0;
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 right after acceptance.
  task automatic send(input logic [7:0] c, input logic [7:0] a, input bit push_en);
    int n;
    bit ok;
    model(c, a, push_en);
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1; in_char = c; in_attr = a;
    do begin
      @(negedge clk_pixel);
      ok = in_ready;
      if (ok) begin
        snap_row = cursor_row; snap_col = cursor_col; snap_scroll = scroll_row;
      end
      n++;
      @(posedge clk_pixel); #1;
    end while (!ok && n < 20000);
    in_valid = 1'b0;
    last_wait = n;
    check("send_accept", 32'(ok), 1);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    do begin
      @(negedge clk_pixel);
      n++;
    end while (!in_ready && n < bound);
    check("idle_reached", 32'(in_ready), 1);
    @(posedge clk_pixel); #1;
  endtask

  task automatic send_idle(input logic [7:0] c, input logic [7:0] a);
    send(c, a, 1'b1);
    wait_idle(3000);
  endtask

  task automatic check_cursor(input string tag, input int r, input int c);
    check(tag, 32'({cursor_row, cursor_col}), 32'({5'(r), 7'(c)}));
  endtask

  // Scoreboard monitor, sampling on the inactive edge.
  always @(negedge clk_pixel) begin
    logic [27:0] e;
    if (!reset) begin
      check("disp_valid_lag", 32'(disp_valid), 32'(prev_req));
      if (disp_req) check("disp_blocks_we", 32'(ram_we), 0);
      if (ram_we) begin
        check("wr_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_addr_data", 32'({ram_addr, ram_wdata}), 32'(e));
        end
      end
    end
    prev_req = disp_req;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int n;
    // Reset state and power-up clear.
    repeat (2) @(negedge clk_pixel);
    check("rst_cursor", 32'({cursor_row, cursor_col}), 0);
    check("rst_scroll", 32'(scroll_row), 0);
    check("rst_we", 32'(ram_we), 0);
    check("rst_disp_valid", 32'(disp_valid), 0);
    check("rst_ready_busy", 32'({in_ready, busy}), 32'(2'b01));
    for (int r = 0; r < ROWS; r++) push_row(r);
    @(posedge clk_pixel); #1;
    reset = 1'b0;
    wait_idle(3000);
    check("init_busy", 32'(busy), 0);
    check("init_queue", 32'(exp_q.size()), 0);

    // Pending write stalled behind a 10-cycle display burst.
    disp_req = 1'b1; disp_row = 5'd3; disp_col = 7'd7;
    send(8'h71, 8'h07, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_pixel);
      check("disp_addr", 32'(ram_addr), 247);
      check("stall_we", 32'(ram_we), 0);
      @(posedge clk_pixel); #1;
    end
    disp_req = 1'b0;
    @(negedge clk_pixel);
    check("release_we", 32'(ram_we), 1);
    check("release_addr", 32'(ram_addr), 0);
    @(posedge clk_pixel); #1;
    wait_idle(10);
    check_cursor("after_stall", 0, 1);

    // CR, newlines, then 'A' at (2,5).
    send_idle(8'h0D, 8'h00);
    check_cursor("after_cr", 0, 0);
    send_idle(8'h0A, 8'h00);
    send_idle(8'h0A, 8'h00);
    for (int i = 0; i < 5; i++) send_idle(8'h78, 8'h07);
    check_cursor("at_2_5", 2, 5);
    exp_q.push_back({12'd165, 16'h1E41});
    send(8'h41, 8'h1E, 1'b0);
    wait_idle(100);
    check_cursor("after_A", 2, 6);

    // Ignored control code, then backspace.
    send_idle(8'h07, 8'h00);
    check_cursor("after_bel", 2, 6);
    send_idle(8'h08, 8'h00);
    check_cursor("after_bs", 2, 5);

    // Walk to (29,79) and overflow the last row.
    for (int i = 0; i < 27; i++) send_idle(8'h0A, 8'h00);
    check_cursor("at_29_0", 29, 0);
    for (int i = 0; i < 79; i++) send_idle(8'h79, 8'h2A);
    check_cursor("at_29_79", 29, 79);
    exp_q.push_back({12'd2399, 16'h2A7A});
    for (int c = 0; c < COLS; c++) exp_q.push_back({12'(c), 16'h0F20});
    send(8'h7A, 8'h2A, 1'b0);
    @(negedge clk_pixel);
    @(posedge clk_pixel); #1;
    @(negedge clk_pixel);
    check("line_busy", 32'(busy), 1);
    check("line_not_ready", 32'(in_ready), 0);
    @(posedge clk_pixel); #1;

    // Form feed held off until the line clear completes.
    send(8'h0C, 8'h00, 1'b1);
    check("ff_held", 32'(last_wait >= 70), 1);
    check("wrap_cursor", 32'({snap_row, snap_col}), 32'({SCROLL ? 5'd29 : 5'd0, 7'd0}));
    check("wrap_scroll", 32'(snap_scroll), SCROLL ? 1 : 0);

    // Reset in the middle of the form-feed clear.
    n = 0;
    hit = 1'b0;
    do begin
      @(negedge clk_pixel);
      hit = ram_we && (ram_addr == 12'd1000);
      n++;
    end while (!hit && n < 3000);
    check("hit_1000", 32'(hit), 1);
    @(posedge clk_pixel); #1;
    reset = 1'b1;
    exp_q.delete();
    exp_row = 0; exp_col = 0; exp_scroll = 0;
    @(negedge clk_pixel);
    check("mid_rst_we", 32'(ram_we), 0);
    check("mid_rst_busy", 32'({in_ready, busy}), 32'(2'b01));
    check_cursor("mid_rst_cursor", 0, 0);
    for (int r = 0; r < ROWS; r++) push_row(r);
    @(posedge clk_pixel); #1;
    reset = 1'b0;
    wait_idle(3000);
    check_cursor("restart_cursor", 0, 0);
    check("restart_queue", 32'(exp_q.size()), 0);

    // Backspace at column 0 is a no-op; at column 1 it blanks column 0.
    send_idle(8'h08, 8'h00);
    check_cursor("bs_col0", 0, 0);
    send_idle(8'h7A, 8'h4F);
    send_idle(8'h08, 8'h00);
    check_cursor("bs_col1", 0, 0);

    repeat (5) @(negedge clk_pixel);
    check("final_queue", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/console_writer.md
CONSOLE_WRITER -- requirements
Module: console_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, text columns per row.
REQ-002 SHALL have parameter ROWS, default 30, text rows on screen.
REQ-003 SHALL have parameter ATTR_BLANK, default 8'h0F, attribute written by all clear operations.
REQ-004 SHALL have port clk_pixel  input  1  pixel clock; the only clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  character stream valid.
REQ-007 SHALL have port in_ready  output  1  character accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port in_char  input  8  codepoint.
REQ-009 SHALL have port in_attr  input  8  attribute for a printable codepoint.
REQ-010 SHALL have port disp_req  input  1  display fetch request this cycle.
REQ-011 SHALL have port disp_row  input  5  logical row being fetched.
REQ-012 SHALL have port disp_col  input  7  column being fetched.
REQ-013 SHALL have port disp_valid  output  1  ram_rdata holds the fetch issued in the previous cycle.
REQ-014 SHALL have port ram_addr  output  12  text RAM address, computed as phys_row*COLS+col.
REQ-015 SHALL have port ram_we  output  1  text RAM write enable.
REQ-016 SHALL have port ram_wdata  output  16  {attribute, codepoint}.
REQ-017 SHALL have port ram_rdata  input  16  text RAM read data, synchronous, 1-cycle latency.
REQ-018 SHALL have port cursor_row, cursor_col  output  5/7  logical cursor position.
REQ-019 SHALL have port scroll_row  output  5  physical row holding logical row 0.
REQ-020 SHALL have port busy  output  1  high while a clear sequence is in progress.

Function
REQ-021 The text RAM port SHALL be arbitrated with strict priority to the display: when disp_req=1, ram_addr SHALL be the fetch address, with phys_row=(disp_row+scroll_row) mod ROWS, and ram_we SHALL be 0.
REQ-022 disp_valid SHALL equal disp_req delayed by exactly one cycle.
REQ-023 Writer accesses SHALL occur only on cycles with disp_req=0; a stalled write or clear SHALL hold its address and data without skipping.
REQ-024 The FSM SHALL have states IDLE, WRITE, CLEAR_LINE and CLEAR_ALL; in_ready SHALL be 1 only in IDLE.
REQ-025 A printable codepoint (0x20-0x7E, 0x80-0xFF) SHALL be accepted in IDLE, move the FSM to WRITE, and write {in_attr,in_char} at the cursor on the first granted cycle.
REQ-026 After a printable write, the FSM SHALL increment cursor_col; when col reaches COLS it SHALL set cursor_col=0 and apply the newline rule.
REQ-027 0x0D SHALL set cursor_col=0 and cause no write.
REQ-028 0x0A SHALL set cursor_col=0 and apply the newline rule.
REQ-029 Newline rule: if cursor_row<ROWS-1, cursor_row SHALL be incremented; otherwise the scroll behaviour of REQ-040 applies.
REQ-030 0x08 SHALL, when cursor_col>0, decrement cursor_col and write {ATTR_BLANK,0x20} there; when cursor_col=0 it SHALL be a no-op.
REQ-031 0x0C SHALL enter CLEAR_ALL, write ROWS*COLS blanks, then set cursor to (0,0) and scroll_row to 0.
REQ-032 Other control codes SHALL be consumed without effect.
REQ-033 CLEAR_LINE SHALL write COLS blanks to one physical row, col 0..COLS-1, advancing only on granted cycles, and return to IDLE after the last write.
REQ-034 busy SHALL be 1 in CLEAR_LINE and CLEAR_ALL and 0 otherwise.
REQ-035 Cursor and scroll_row updates SHALL take effect in the cycle the FSM returns to IDLE.

Reset
REQ-036 On reset assertion, the block SHALL set cursor_row=0, cursor_col=0, scroll_row=0, ram_we=0, disp_valid=0, in_ready=0 and busy=1.
REQ-037 On reset the FSM SHALL enter CLEAR_ALL so that the screen is blanked after release.
REQ-038 A reset asserted mid-clear or mid-write SHALL abort the operation, and the clear SHALL restart from address 0.

Configuration
REQ-039 Macro CONSOLE_WRITER_SCROLL_EN SHALL select the scroll behaviour.
REQ-040 With CONSOLE_WRITER_SCROLL_EN defined, a newline at row ROWS-1 SHALL keep cursor_row=ROWS-1, set scroll_row=(scroll_row+1) mod ROWS, and CLEAR_LINE the old scroll_row physical row.
REQ-041 Without CONSOLE_WRITER_SCROLL_EN, a newline at row ROWS-1 SHALL set cursor_row=0 and CLEAR_LINE physical row 0, and scroll_row SHALL be tied to 0.

Structure
REQ-042 Package console_pkg SHALL hold the COLS/ROWS defaults, the ASCII control constants (CR, LF, BS, FF, SPACE) and the FSM state enum.
REQ-043 Sub-module console_addr_gen SHALL compute phys_row=(row+offset) mod ROWS and address=phys_row*COLS+col, and SHALL be shared by the display and writer paths.

Verification
REQ-044 Release reset, disp_req=0 -> exactly 2400 writes of 16'h0F20 to addresses 0..2399, then busy=0 and in_ready=1.
REQ-045 Send 'A' (8'h41) with attr 8'h1E at cursor (2,5), scroll_row 0 -> one write of 16'h1E41 to address 165, and cursor_col becomes 6.
REQ-046 Hold disp_req=1 for 10 cycles during a pending write -> ram_we=0 for those cycles, the write completes on the first cycle after disp_req falls, and disp_valid lags disp_req by 1 cycle.
REQ-047 Cursor (29,79), printable char, with SCROLL_EN -> write to address 2399, then scroll_row=1, physical row 0 cleared at addresses 0..79, cursor (29,0).
REQ-048 Cursor (0,0) with 0x08 -> no write and no cursor change; 0x0C mid-CLEAR_LINE -> not accepted until busy=0.
REQ-049 Assert reset at clear address 1000 -> on release, the clear restarts at address 0 and the cursor is (0,0).
